conv2d_1x1_mac_stream: RTL and testbench

CONV2D_1X1_MAC_STREAM -- requirements
Module: conv2d_1x1_mac_stream

---
 rtl/conv2d_1x1_mac_stream.sv | 157 +++++++++++++++
 tb/tb_conv2d_1x1_mac_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_1x1_mac_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_1x1_mac_stream
// Description : Streaming 1x1 convolution MAC. Accumulates NUM_CH_IN
//               Data_In*Kernel products plus a bias per output pixel, then
//               rounds, saturates and optionally ReLU-clamps the result into
//               a 1-entry output register with valid/ready handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_1x1_mac_stream #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int NUM_CH_IN = 4,
    parameter int ACC_W     = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Data_In,
    input  logic [DATA_W-1:0] Kernel,
    input  logic [DATA_W-1:0] Bias,
    input  logic              Relu_En,
    input  logic              Valid_In,
    output logic              Ready_In,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Valid_Out,
    input  logic              Ready_Out,
    output logic [7:0]        Ch_Idx
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [7:0]              C_LAST_CH = 8'(NUM_CH_IN - 1);
    localparam logic signed [ACC_W-1:0] C_HALF    = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] C_SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Parameter sanity: the accumulator must hold NUM_CH_IN full products plus bias.
    if ((ACC_W < 2*DATA_W + $clog2(NUM_CH_IN) + 1) || (FRAC_W < 1) ||
        (NUM_CH_IN < 1) || (NUM_CH_IN > 256)) begin : g_param_check
        $error("conv2d_1x1_mac_stream: illegal parameter combination");
    end

    state_t                    state_q, state_d;
    logic [7:0]                ch_idx_q, ch_idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      relu_q, relu_d;
    logic [DATA_W-1:0]         dout_q, dout_d;
    logic                      vout_q, vout_d;

    logic [2*DATA_W-1:0]       w_din_ext;
    logic [2*DATA_W-1:0]       w_ker_ext;
    logic [2*DATA_W-1:0]       w_prod_full;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_rounded;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [DATA_W-1:0]         w_result;
    logic                      w_first;
    logic                      w_last;
    logic                      w_relu;
    logic                      w_accept;

    // A new beat can enter whenever the output register is empty or draining.
    assign Ready_In  = !vout_q || Ready_Out;
    assign w_accept  = Valid_In && Ready_In;
    assign Data_Out  = dout_q;
    assign Valid_Out = vout_q;
    assign Ch_Idx    = ch_idx_q;

    // Datapath: product, running sum including this beat, and the rounded/saturated result.
    always_comb begin
        // Sign-extend operands to the product width so the low half of an
        // unsigned multiply is the exact two's-complement product.
        w_din_ext   = {{DATA_W{Data_In[DATA_W-1]}}, Data_In};
        w_ker_ext   = {{DATA_W{Kernel[DATA_W-1]}}, Kernel};
        w_prod_full = w_din_ext * w_ker_ext;
        w_prod_ext  = {{(ACC_W-2*DATA_W){w_prod_full[2*DATA_W-1]}}, w_prod_full};
        w_bias_ext  = {{(ACC_W-DATA_W){Bias[DATA_W-1]}}, Bias} << FRAC_W;

        w_first = (state_q == IDLE);
        w_last  = (ch_idx_q == C_LAST_CH);
        // On the first beat the bias seeds the sum instead of the (empty) accumulator.
        w_sum   = (w_first ? w_bias_ext : acc_q) + w_prod_ext;
        w_relu  = w_first ? Relu_En : relu_q;

        w_rounded = w_sum + C_HALF;
        w_shifted = w_rounded >>> FRAC_W;

        w_result = w_shifted[DATA_W-1:0];
        if (w_shifted > C_SAT_MAX) begin
            w_result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shifted < C_SAT_MIN) begin
            w_result = {1'b1, {(DATA_W-1){1'b0}}};
        end
        if (w_relu && w_result[DATA_W-1]) begin
            w_result = '0;
        end
    end

    // Next-state logic for the channel FSM, accumulator and output register.
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        acc_d    = acc_q;
        relu_d   = relu_q;
        dout_d   = dout_q;
        vout_d   = vout_q;

        if (w_accept && w_first) begin
            relu_d = Relu_En;
        end

        if (w_accept) begin
            if (w_last) begin
                state_d  = IDLE;
                ch_idx_d = '0;
                acc_d    = '0;
                dout_d   = w_result;
                vout_d   = 1'b1;
            end else begin
                state_d  = ACCUM;
                ch_idx_d = ch_idx_q + 8'd1;
                acc_d    = w_sum;
            end
        end

        // Drain the output register unless a fresh result replaces it this edge.
        if (vout_q && Ready_Out && !(w_accept && w_last)) begin
            vout_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_idx_q <= '0;
            acc_q    <= '0;
            relu_q   <= 1'b0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            acc_q    <= acc_d;
            relu_q   <= relu_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_1x1_mac_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_1x1_mac_stream
// Description : Self-checking bench for conv2d_1x1_mac_stream. A pixel-level
//               arithmetic model predicts output valid/data, channel index
//               and input readiness every cycle; directed tests also pin
//               literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_1x1_mac_stream;

    localparam int DW  = 16;
    localparam int FW  = 8;
    localparam int NCH = 4;
    localparam int AW  = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] Data_In;
    logic [DW-1:0] Kernel;
    logic [DW-1:0] Bias;
    logic          Relu_En;
    logic          Valid_In;
    logic          Ready_In;
    logic [DW-1:0] Data_Out;
    logic          Valid_Out;
    logic          Ready_Out;
    logic [7:0]    Ch_Idx;

    conv2d_1x1_mac_stream #(
        .DATA_W    (DW),
        .FRAC_W    (FW),
        .NUM_CH_IN (NCH),
        .ACC_W     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Data_In   (Data_In),
        .Kernel    (Kernel),
        .Bias      (Bias),
        .Relu_En   (Relu_En),
        .Valid_In  (Valid_In),
        .Ready_In  (Ready_In),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out),
        .Ready_Out (Ready_Out),
        .Ch_Idx    (Ch_Idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Pixel-level model state
    int m_cnt = 0;
    int m_d [NCH];
    int m_k [NCH];
    int m_bias = 0;
    bit m_relu = 1'b0;
    bit exp_valid = 1'b0;
    int exp_data = 0;
    int consumed [$];
    int out_idx = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel result from plain integer arithmetic: bias*2^FW + sum of products,
    // round half up, shift, saturate, optional ReLU.
    function automatic int pixel_result();
        longint s;
        s = longint'(m_bias) * 256;
        for (int i = 0; i < NCH; i++) begin
            s += longint'(m_d[i]) * longint'(m_k[i]);
        end
        s = (s + 128) >>> 8;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (m_relu && s < 0) s = 0;
        return int'(s);
    endfunction

    // Per-cycle compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        bit acc;
        bit last;
        if (check_en) begin
            chk("valid_out", Valid_Out, exp_valid);
            if (exp_valid) chk("data_out", $signed(Data_Out), exp_data);
            chk("ch_idx", Ch_Idx, m_cnt);
            chk("ready_in", Ready_In, (!exp_valid || Ready_Out));
            if (Valid_Out && Ready_Out && !rst) consumed.push_back(int'($signed(Data_Out)));
        end
        if (rst) begin
            m_cnt     = 0;
            exp_valid = 1'b0;
            exp_data  = 0;
        end else begin
            acc  = Valid_In && (!exp_valid || Ready_Out);
            last = 1'b0;
            if (acc) begin
                m_d[m_cnt] = int'($signed(Data_In));
                m_k[m_cnt] = int'($signed(Kernel));
                if (m_cnt == 0) begin
                    m_bias = int'($signed(Bias));
                    m_relu = Relu_En;
                end
                m_cnt++;
                if (m_cnt == NCH) begin
                    last      = 1'b1;
                    m_cnt     = 0;
                    exp_data  = pixel_result();
                    exp_valid = 1'b1;
                end
            end
            if (!last && exp_valid && Ready_Out) exp_valid = 1'b0;
        end
    end

    // Present one beat (after optional idle cycles) and hold it until accepted.
    task automatic send(input int d, input int k, input int b, input bit r, input int gap);
        bit ok;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        Data_In  = DW'(d);
        Kernel   = DW'(k);
        Bias     = DW'(b);
        Relu_En  = r;
        Valid_In = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            ok = Ready_In;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat not accepted, actual ready 0 required 1");
        end
        Valid_In = 1'b0;
    endtask

    // Wait for the next consumed output and compare it with a literal.
    task automatic expect_out(input string name, input int lit);
        for (int n = 0; n < 40 && consumed.size() <= out_idx; n++) @(posedge clk);
        #1;
        if (consumed.size() <= out_idx) begin
            checks++;
            errors++;
            $display("FAIL %s: no output produced, required %0d", name, lit);
        end else begin
            chk(name, consumed[out_idx], lit);
            out_idx++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        Valid_In  = 1'b0;
        Ready_Out = 1'b1;
        Data_In   = '0;
        Kernel    = '0;
        Bias      = '0;
        Relu_En   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("rst_data_out", Data_Out, 0);
        chk("rst_valid_out", Valid_Out, 0);
        chk("rst_ch_idx", Ch_Idx, 0);
        chk("rst_ready_in", Ready_In, 1);
        rst = 1'b0;

        // Basic: 4 x 256*128 -> 512
        for (int i = 0; i < NCH; i++) send(256, 128, 0, 1'b0, 0);
        expect_out("basic", 512);

        // Bias/rounding with bubbles; bias sampled only on first beat -> 257
        send(1, 32, 256, 1'b0, 0);
        for (int i = 1; i < NCH; i++) send(1, 32, 999, 1'b0, 2);
        expect_out("bias_round", 257);

        // Saturation both directions
        for (int i = 0; i < NCH; i++) send(32767, 32767, 0, 1'b0, 0);
        expect_out("sat_pos", 32767);
        for (int i = 0; i < NCH; i++) send(32767, -32768, 0, 1'b0, 0);
        expect_out("sat_neg", -32768);

        // ReLU latched on first beat only
        send(256, -256, 0, 1'b1, 0);
        for (int i = 1; i < NCH; i++) send(256, -256, 0, 1'b0, 0);
        expect_out("relu_on", 0);
        for (int i = 0; i < NCH; i++) send(256, -256, 0, 1'b0, 0);
        expect_out("relu_off", -1024);

        // Backpressure: two pixels while the consumer stalls
        Ready_Out = 1'b0;
        fork
            begin
                for (int i = 0; i < NCH; i++) send(256, 128, 0, 1'b0, 0);
                for (int i = 0; i < NCH; i++) send(256, 256, 0, 1'b0, 0);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                chk("bp_ready_in_low", Ready_In, 0);
                chk("bp_hold_data", $signed(Data_Out), 512);
                chk("bp_hold_valid", Valid_Out, 1);
                repeat (4) @(posedge clk);
                #1;
                Ready_Out = 1'b1;
            end
        join
        expect_out("bp_first", 512);
        expect_out("bp_second", 1024);

        // Reset mid-pixel discards partial accumulation
        send(1000, 1000, 500, 1'b0, 0);
        send(1000, 1000, 500, 1'b0, 0);
        chk("pre_rst_ch_idx", Ch_Idx, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_ch_idx", Ch_Idx, 0);
        chk("post_rst_valid", Valid_Out, 0);
        for (int i = 0; i < NCH; i++) send(256, 128, 0, 1'b0, 0);
        expect_out("after_rst", 512);

        repeat (3) @(posedge clk);
        #1;
        chk("final_count", consumed.size(), 9);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
